br_recovery_ctrl: RTL and testbench
===================================

Name: br_recovery_ctrl

Overview:
- Sequences branch resolution for the EX stage of the pipelined agree-predictor core.
- Takes the branch unit's true decision plus the prediction carried down the pipe, and detects mispredicts.
- On a mispredict it drives a one-cycle redirect and a flush of IF/ID and ID/EX.
- Queues one predictor-update record per resolved branch in a small FIFO, drained by the predictor tables via valid/ready. Stalls EX when that FIFO cannot accept a record.

Parameters:
- UPD_DEPTH, 4: update FIFO entries; power of two, ≥2.
- CNT_W, 32: width of the branch and mispredict counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ex_valid_i  in  1  EX holds a valid instruction
- ex_is_br_i  in  1  conditional branch in EX
- ex_is_uncbr_i  in  1  JAL/JALR in EX
- ex_pc_i  in  32  PC of the EX instruction
- ex_target_i  in  32  computed branch/jump target
- true_br_decision_i  in  1  resolved taken, from the branch unit
- ex_pred_taken_i  in  1  predicted taken
- ex_pred_target_i  in  32  predicted target
- ex_bias_i  in  1  agree bias bit used at prediction
- redirect_valid_o  out  1  fetch must load redirect_pc_o
- redirect_pc_o  out  32  corrected fetch PC
- flush_if_id_o  out  1  squash the IF/ID register
- flush_id_ex_o  out  1  squash the ID/EX register
- stall_o  out  1  hold EX and all earlier stages
- upd_valid_o  out  1  FIFO head valid
- upd_ready_i  in  1  predictor accepts the head
- upd_pc_o  out  32  head: branch PC
- upd_taken_o  out  1  head: resolved direction
- upd_agree_o  out  1  head: taken == bias
- upd_target_o  out  32  head: resolved target
- br_cnt_o  out  CNT_W  resolved branches, wraps
- mispred_cnt_o  out  CNT_W  mispredicts, wraps

Behaviour:
- **Reset:** all outputs 0; FIFO emptied; counters 0; state IDLE. Reset mid-recovery or with a non-empty FIFO discards everything.
- **Resolve condition:** resolve = ex_valid_i & (ex_is_br_i | ex_is_uncbr_i) & state==IDLE & ~stall_o.
- **Mispredict:** mispred = resolve & (true_br_decision_i != ex_pred_taken_i | (true_br_decision_i & ex_target_i != ex_pred_target_i)).
- **Corrected PC:** true_br_decision_i ? ex_target_i : ex_pc_i + 4, computed mod 2^32.
- **FSM, IDLE:**
  - On mispred (cycle N): latch the corrected PC; go to RECOVER.
  - Otherwise stay in IDLE.
- **FSM, RECOVER (cycle N+1):**
  - redirect_valid_o = flush_if_id_o = flush_id_ex_o = 1.
  - EX inputs are ignored, since that instruction is wrong-path.
  - Return to IDLE unconditionally.
- **Redirect/flush timing:** pulses last exactly one cycle. Outputs are registered; redirect_pc_o holds its value outside the pulse.
- **Back-to-back:** a branch arriving in EX in the cycle after RECOVER is resolved normally.
- **FIFO push:** push = resolve. Entry = {ex_pc_i, true_br_decision_i, true_br_decision_i==ex_bias_i, ex_target_i}. Unconditional jumps also push.
- **FIFO pop:** pop = upd_valid_o & upd_ready_i. Head fields are stable while upd_valid_o=1 and ready is low.
- **Stall:** stall_o = ex_valid_i & (ex_is_br_i|ex_is_uncbr_i) & state==IDLE & full & ~pop. Combinational.
  - While stalled: no push, no mispredict evaluation, no counting.
- **Simultaneous push/pop:**
  - When full: both take effect, count unchanged.
  - When empty: push only; upd_valid_o rises the next cycle. There is no bypass.
- **Pointers:** wrap modulo UPD_DEPTH. Occupancy counter width is log2(UPD_DEPTH)+1.
- **Counters:** br_cnt_o increments on resolve; mispred_cnt_o increments on mispred. Both wrap at 2^CNT_W.

Decomposition:
- **Shared package br_ctrl_pkg:**
  - rec_state_e enum {IDLE, RECOVER}
  - upd_entry_t packed struct {pc, taken, agree, target}
  - PC_INC = 32'd4
- **Sub-module br_upd_fifo:** parameterised on UPD_DEPTH and upd_entry_t. Provides push/pop, full/empty, and head output.

Test Plan:
- **Correct not-taken:** BEQ at pc 0x100, pred_taken=0, decision=0, bias=0 -> no redirect/flush; one FIFO entry {0x100,0,1,target}; br_cnt=1, mispred_cnt=0.
- **Direction mispredict:** BNE at 0x200, pred_taken=0, decision=1, target 0x240 -> redirect_valid_o=1 with pc 0x240 exactly one cycle later, both flushes=1 in that cycle. A valid branch in EX during RECOVER is not pushed or counted.
- **Target mispredict:** JALR at 0x300, pred_taken=1, pred_target 0x400, target 0x480 -> redirect to 0x480; agree=bias. Also not-taken mispredict at 0xFFFFFFFC -> redirect 0x00000000 (wrap).
- **FIFO full:** upd_ready_i=0, 4 branches resolved, 5th branch held -> stall_o=1, no push, counters frozen. Raising upd_ready_i -> stall_o drops the same cycle, the push and pop both happen, and order is preserved.
- **Backpressure:** upd_ready_i toggling 1-0-1 while 3 entries queued -> head fields stable while ready is low; entries emerge in push order.
- **Reset mid-recovery:** rst_i asserted in RECOVER with 2 FIFO entries -> the next cycle all outputs are 0, upd_valid_o=0, counters 0.

Source files
------------

// File: rtl/br_recovery_ctrl_pkg.sv
// Shared types for EX-stage branch resolution: recovery FSM states,
// the predictor-update record, and the sequential fetch increment.
package br_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } rec_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        agree;
        logic [31:0] target;
    } upd_entry_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/br_upd_fifo.sv
// Predictor-update queue. The head is shown only while non-empty, and a push
// into a full queue is accepted only when the head leaves in the same cycle.
module br_upd_fifo
    import br_ctrl_pkg::*;
#(
    parameter int  UPD_DEPTH = 4,
    parameter type T         = upd_entry_t
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output T     o_head
);

    localparam int PTR_W = $clog2(UPD_DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    T                 r_mem [UPD_DEPTH];

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == (PTR_W+1)'(UPD_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_head    = o_empty ? T'('0) : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data-only; stale slots are never visible through o_head.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/br_recovery_ctrl.sv
// EX-stage branch resolution: mispredict detection, one-cycle redirect/flush,
// predictor-update queueing with EX stall on a full queue, and statistics.
module br_recovery_ctrl
    import br_ctrl_pkg::*;
#(
    parameter int UPD_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_br_i,
    input  logic             ex_is_uncbr_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_target_i,
    input  logic             true_br_decision_i,
    input  logic             ex_pred_taken_i,
    input  logic [31:0]      ex_pred_target_i,
    input  logic             ex_bias_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             stall_o,
    output logic             upd_valid_o,
    input  logic             upd_ready_i,
    output logic [31:0]      upd_pc_o,
    output logic             upd_taken_o,
    output logic             upd_agree_o,
    output logic [31:0]      upd_target_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    rec_state_e       r_state;
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    logic        w_ex_br;
    logic        w_idle;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_stall;
    logic        w_resolve;
    logic        w_mispred;
    logic [31:0] w_corr_pc;
    upd_entry_t  w_entry;
    upd_entry_t  w_head;

    assign w_ex_br   = ex_valid_i & (ex_is_br_i | ex_is_uncbr_i);
    assign w_idle    = (r_state == IDLE);
    assign w_pop     = upd_valid_o & upd_ready_i;
    assign w_stall   = w_ex_br & w_idle & w_full & ~w_pop;
    assign w_resolve = w_ex_br & w_idle & ~w_stall;
    assign w_mispred = w_resolve &
                       ((true_br_decision_i != ex_pred_taken_i) |
                        (true_br_decision_i & (ex_target_i != ex_pred_target_i)));
    assign w_corr_pc = true_br_decision_i ? ex_target_i : ex_pc_i + PC_INC;
    assign w_entry   = {ex_pc_i, true_br_decision_i,
                        true_br_decision_i == ex_bias_i, ex_target_i};

    br_upd_fifo #(
        .UPD_DEPTH (UPD_DEPTH),
        .T         (upd_entry_t)
    ) u_upd_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_resolve),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Redirect and both flushes are one registered pulse raised while in RECOVER.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mispred) begin
                        r_state       <= RECOVER;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_corr_pc;
                    end else begin
                        r_redirect    <= 1'b0;
                    end
                end
                RECOVER: begin
                    r_state    <= IDLE;
                    r_redirect <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_resolve) r_br_cnt  <= r_br_cnt + CNT_W'(1);
            if (w_mispred) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
    end

    assign redirect_valid_o = r_redirect;
    assign flush_if_id_o    = r_redirect;
    assign flush_id_ex_o    = r_redirect;
    assign redirect_pc_o    = r_redirect_pc;
    assign stall_o          = w_stall;
    assign upd_valid_o      = ~w_empty;
    assign upd_pc_o         = w_head.pc;
    assign upd_taken_o      = w_head.taken;
    assign upd_agree_o      = w_head.agree;
    assign upd_target_o     = w_head.target;
    assign br_cnt_o         = r_br_cnt;
    assign mispred_cnt_o    = r_mis_cnt;

endmodule

// File: tb/tb_br_recovery_ctrl.sv
// Scoreboard bench for br_recovery_ctrl: directed branch vectors push expected
// update records and redirects; a negedge monitor pops and compares them.
module tb_br_recovery_ctrl;
    import br_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_is_br_i, ex_is_uncbr_i;
    logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
    logic        true_br_decision_i, ex_pred_taken_i, ex_bias_i;
    logic        redirect_valid_o, flush_if_id_o, flush_id_ex_o, stall_o;
    logic [31:0] redirect_pc_o;
    logic        upd_valid_o, upd_ready_i, upd_taken_o, upd_agree_o;
    logic [31:0] upd_pc_o, upd_target_o;
    logic [31:0] br_cnt_o, mispred_cnt_o;

    br_recovery_ctrl #(.UPD_DEPTH(4), .CNT_W(32)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ex_valid_i         (ex_valid_i),
        .ex_is_br_i         (ex_is_br_i),
        .ex_is_uncbr_i      (ex_is_uncbr_i),
        .ex_pc_i            (ex_pc_i),
        .ex_target_i        (ex_target_i),
        .true_br_decision_i (true_br_decision_i),
        .ex_pred_taken_i    (ex_pred_taken_i),
        .ex_pred_target_i   (ex_pred_target_i),
        .ex_bias_i          (ex_bias_i),
        .redirect_valid_o   (redirect_valid_o),
        .redirect_pc_o      (redirect_pc_o),
        .flush_if_id_o      (flush_if_id_o),
        .flush_id_ex_o      (flush_id_ex_o),
        .stall_o            (stall_o),
        .upd_valid_o        (upd_valid_o),
        .upd_ready_i        (upd_ready_i),
        .upd_pc_o           (upd_pc_o),
        .upd_taken_o        (upd_taken_o),
        .upd_agree_o        (upd_agree_o),
        .upd_target_o       (upd_target_o),
        .br_cnt_o           (br_cnt_o),
        .mispred_cnt_o      (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        int          at;
    } redir_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         exp_br  = 0;
    int         exp_mis = 0;
    upd_entry_t uq[$];
    redir_t     rq[$];
    logic       hold_prev = 1'b0;
    upd_entry_t prev_head;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        redir_t     r;
        upd_entry_t e;
        upd_entry_t h;
        h = '{pc: upd_pc_o, taken: upd_taken_o, agree: upd_agree_o, target: upd_target_o};
        if (rq.size() != 0 && rq[0].at < cyc) begin
            r = rq.pop_front();
            n_tests++; n_fail++;
            $display("FAIL redirect_missing: got none, expected pc 0x%0h at cycle %0d", r.pc, r.at);
        end
        if (redirect_valid_o) begin
            if (rq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL redirect_unexpected: got pc 0x%0h at cycle %0d, expected none", redirect_pc_o, cyc);
            end else begin
                r = rq.pop_front();
                check("redirect_pc", 64'(redirect_pc_o), 64'(r.pc));
                check("redirect_cycle", 64'(cyc), 64'(r.at));
            end
        end
        if (redirect_valid_o || flush_if_id_o || flush_id_ex_o) begin
            check("flush_if_id", 64'(flush_if_id_o), 64'(1'b1));
            check("flush_id_ex", 64'(flush_id_ex_o), 64'(1'b1));
            check("redirect_valid", 64'(redirect_valid_o), 64'(1'b1));
        end
        if (upd_valid_o && hold_prev)
            check("upd_hold", 64'(h.pc ^ prev_head.pc) | 64'(h.target ^ prev_head.target)
                  | 64'({h.taken, h.agree} ^ {prev_head.taken, prev_head.agree}), 64'(0));
        if (upd_valid_o && upd_ready_i) begin
            if (uq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL upd_unexpected: got pc 0x%0h, expected none", upd_pc_o);
            end else begin
                e = uq.pop_front();
                check("upd_pc",     64'(h.pc),     64'(e.pc));
                check("upd_taken",  64'(h.taken),  64'(e.taken));
                check("upd_agree",  64'(h.agree),  64'(e.agree));
                check("upd_target", 64'(h.target), 64'(e.target));
            end
        end
        hold_prev = upd_valid_o && !upd_ready_i;
        prev_head = h;
    end

    task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input logic dec,
                         input logic pred, input logic [31:0] ptgt, input logic bias,
                         input logic unc, input logic rdy, input logic exp_res,
                         input logic exp_stall);
        @(posedge clk_i); #1;
        ex_valid_i = 1'b1; ex_is_br_i = ~unc; ex_is_uncbr_i = unc;
        ex_pc_i = pc; ex_target_i = tgt; true_br_decision_i = dec;
        ex_pred_taken_i = pred; ex_pred_target_i = ptgt; ex_bias_i = bias;
        upd_ready_i = rdy;
        @(negedge clk_i);
        check("stall", 64'(stall_o), 64'(exp_stall));
        if (exp_res) begin
            uq.push_back('{pc: pc, taken: dec, agree: (dec == bias), target: tgt});
            exp_br++;
            if ((dec != pred) || (dec && tgt != ptgt)) begin
                rq.push_back('{pc: (dec ? tgt : pc + 32'd4), at: cyc + 1});
                exp_mis++;
            end
        end
    endtask

    task automatic idle(input logic rdy);
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0; ex_is_br_i = 1'b0; ex_is_uncbr_i = 1'b0;
        upd_ready_i = rdy;
        @(negedge clk_i);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_redirect"},   64'(redirect_valid_o), 64'(0));
        check({tag, "_redir_pc"},   64'(redirect_pc_o),    64'(0));
        check({tag, "_flush"},      64'({flush_if_id_o, flush_id_ex_o}), 64'(0));
        check({tag, "_stall"},      64'(stall_o),          64'(0));
        check({tag, "_upd_valid"},  64'(upd_valid_o),      64'(0));
        check({tag, "_upd_fields"}, 64'(upd_pc_o | upd_target_o) | 64'({upd_taken_o, upd_agree_o}), 64'(0));
        check({tag, "_br_cnt"},     64'(br_cnt_o),         64'(0));
        check({tag, "_mis_cnt"},    64'(mispred_cnt_o),    64'(0));
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_br_cnt"},  64'(br_cnt_o),      64'(exp_br));
        check({tag, "_mis_cnt"}, 64'(mispred_cnt_o), 64'(exp_mis));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish within 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; upd_ready_i = 1'b0;
        ex_valid_i = 1'b0; ex_is_br_i = 1'b0; ex_is_uncbr_i = 1'b0;
        ex_pc_i = '0; ex_target_i = '0; true_br_decision_i = 1'b0;
        ex_pred_taken_i = 1'b0; ex_pred_target_i = '0; ex_bias_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_zero("reset");
        @(posedge clk_i); #1 rst_i = 1'b0;

        // correct not-taken BEQ
        issue(32'h100, 32'h180, 0, 0, 32'h0, 0, 0, 1, 1, 0);
        idle(1); idle(1);
        check_cnt("not_taken");

        // direction mispredict, wrong-path branch during RECOVER, then back-to-back
        issue(32'h200, 32'h240, 1, 0, 32'h0, 1, 0, 1, 1, 0);
        issue(32'h204, 32'h260, 1, 0, 32'h0, 1, 0, 1, 0, 0);
        issue(32'h208, 32'h280, 0, 0, 32'h0, 1, 0, 1, 1, 0);
        idle(1); idle(1);
        check_cnt("dir_mis");

        // target mispredict on JALR, then not-taken mispredict wrapping the PC
        issue(32'h300, 32'h480, 1, 1, 32'h400, 0, 1, 1, 1, 0);
        idle(1);
        issue(32'hFFFF_FFFC, 32'h10, 0, 1, 32'h10, 1, 0, 1, 1, 0);
        idle(1); idle(1);
        check_cnt("tgt_mis");

        // fill the queue under backpressure, stall the fifth, release
        issue(32'h500, 32'h5A0, 0, 0, 32'h0, 0, 0, 0, 1, 0);
        issue(32'h504, 32'h5A4, 1, 1, 32'h5A4, 1, 0, 0, 1, 0);
        issue(32'h508, 32'h5A8, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        issue(32'h50C, 32'h5AC, 1, 1, 32'h5AC, 0, 0, 0, 1, 0);
        issue(32'h510, 32'h5B0, 1, 1, 32'h5B0, 1, 0, 0, 0, 1);
        issue(32'h510, 32'h5B0, 1, 1, 32'h5B0, 1, 0, 0, 0, 1);
        check_cnt("full_frozen");
        issue(32'h510, 32'h5B0, 1, 1, 32'h5B0, 1, 0, 1, 1, 0);
        repeat (6) idle(1);
        check_cnt("full_release");

        // ready toggling with three entries queued
        issue(32'h520, 32'h620, 1, 1, 32'h620, 1, 0, 0, 1, 0);
        issue(32'h524, 32'h624, 0, 0, 32'h0, 1, 0, 0, 1, 0);
        issue(32'h528, 32'h628, 1, 1, 32'h628, 0, 0, 0, 1, 0);
        idle(0); idle(1); idle(0); idle(0); idle(1);
        repeat (4) idle(1);
        check_cnt("backpressure");

        // reset while in RECOVER with two entries queued
        issue(32'h600, 32'h700, 0, 0, 32'h0, 0, 0, 0, 1, 0);
        issue(32'h604, 32'h740, 1, 0, 32'h0, 1, 0, 0, 1, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1; ex_valid_i = 1'b0; ex_is_br_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        uq.delete(); exp_br = 0; exp_mis = 0;
        @(negedge clk_i);
        check_zero("mid_reset");
        @(posedge clk_i); #1 rst_i = 1'b0;

        issue(32'h800, 32'h900, 1, 1, 32'h900, 1, 0, 1, 1, 0);
        idle(1); idle(1); idle(1);
        check_cnt("after_reset");

        check("upd_queue_drained",   64'(uq.size()), 64'(0));
        check("redir_queue_drained", 64'(rq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
